// File: rtl/shifter_seq.sv
// ----------------------------------------------------------------------------
// shifter_seq: multi-cycle shift unit for the 16-bit datapath.
//
// Applies one single-position shift per clock, for a programmable amount
// of 0..2^AW-1 positions. The controller issues a start pulse while the
// unit is idle, watches busy, and takes the result when done pulses. The
// result and carry stay on sout/carry until the next accepted start.
//
// Op codes: 00 none, 01 left, 10 logical right, 11 arithmetic right.
//
// Optional build macro: SHIFTER_ROTATE_EN
//   defined   - op 00 with a nonzero amount rotates right, one position
//               per cycle, with the same latency as the other shifts.
//   undefined - op 00 passes the operand through for any amount and
//               finishes one edge after the start is accepted.
// ----------------------------------------------------------------------------
module shifter_seq #(
    parameter int W  = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  in,
    input  logic [1:0]    shift,
    input  logic [AW-1:0] amt,
    output logic [W-1:0]  sout,
    output logic          carry,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_LSL  = 2'b01;
    localparam logic [1:0] OP_LSR  = 2'b10;
    localparam logic [1:0] OP_ASR  = 2'b11;

`ifdef SHIFTER_ROTATE_EN
    localparam logic ROTATE_EN = 1'b1;
`else
    localparam logic ROTATE_EN = 1'b0;
`endif

    state_t        state_q;
    logic [W-1:0]  sout_q;
    logic          carry_q;
    logic [1:0]    op_q;
    logic [AW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;

    logic [W-1:0]  step_sout_d;
    logic          step_carry_d;
    logic          skip_shift;

    // One shift step applied to the current contents, selected by the
    // captured op code.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        step_sout_d  = sout_q;
        step_carry_d = carry_q;
        case (op_q)
            OP_LSL: begin
                step_sout_d  = {sout_q[W-2:0], 1'b0};
                step_carry_d = sout_q[W-1];
            end
            OP_LSR: begin
                step_sout_d  = {1'b0, sout_q[W-1:1]};
                step_carry_d = sout_q[0];
            end
            OP_ASR: begin
                step_sout_d  = {sout_q[W-1], sout_q[W-1:1]};
                step_carry_d = sout_q[0];
            end
            default: begin
`ifdef SHIFTER_ROTATE_EN
                step_sout_d  = {sout_q[0], sout_q[W-1:1]};
                step_carry_d = sout_q[0];
`endif
            end
        endcase
    end

    // A start that needs no shifting goes straight to DONE.
    assign skip_shift = (amt == '0) || ((shift == OP_NONE) && !ROTATE_EN);

    // Control FSM plus datapath registers; busy/done are registered so no
    // input reaches an output combinationally.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: every state bit is cleared by the asynchronous reset so an
        // operation in flight is abandoned at once, with no clock needed.
        if (reset) begin
            state_q <= S_IDLE;
            sout_q  <= '0;
            carry_q <= 1'b0;
            op_q    <= OP_NONE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, regardless of statement order.
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sout_q  <= in;
                        op_q    <= shift;
                        cnt_q   <= amt;
                        carry_q <= 1'b0;
                        if (skip_shift) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_SHIFT;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    sout_q  <= step_sout_d;
                    carry_q <= step_carry_d;
                    cnt_q   <= cnt_q - AW'(1);
                    if (cnt_q == AW'(1)) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sout  = sout_q;
    assign carry = carry_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_shifter_seq.sv
// ----------------------------------------------------------------------------
// tb_shifter_seq: self-checking bench for shifter_seq.
// A transaction-level model predicts sout/carry/busy/done from the operand,
// op code and number of edges since acceptance; a compare process checks the
// DUT against it every cycle. Directed sequences add literal expectations.
// Build with or without SHIFTER_ROTATE_EN.
// ----------------------------------------------------------------------------
module tb_shifter_seq;

    localparam int W  = 16;
    localparam int AW = 4;

`ifdef SHIFTER_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          start;
    logic [W-1:0]  in_s;
    logic [1:0]    shift_s;
    logic [AW-1:0] amt_s;
    logic [W-1:0]  sout;
    logic          carry;
    logic          busy;
    logic          done;

    int tests;
    int fails;

    shifter_seq #(.W(W), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .in    (in_s),
        .shift (shift_s),
        .amt   (amt_s),
        .sout  (sout),
        .carry (carry),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result of shifting v by n positions under op: {carry, sout}.
    function automatic logic [W:0] model_shift(input logic [W-1:0] v, input logic [1:0] op, input int n);
        logic [W-1:0] r;
        logic         c;
        if (n == 0) return {1'b0, v};
        case (op)
            2'b01: begin r = v << n; c = v[W-n]; end
            2'b10: begin r = v >> n; c = v[n-1]; end
            2'b11: begin r = W'($signed(v) >>> n); c = v[n-1]; end
            default: begin
                if (ROT) begin r = (v >> n) | (v << (W - n)); c = v[n-1]; end
                else     begin r = v; c = 1'b0; end
            end
        endcase
        return {c, r};
    endfunction

    // Model state: the accepted transaction and edges elapsed since it.
    bit           m_active;
    bit           m_idle;
    int           m_e;
    int           m_len;
    logic [W-1:0] m_in;
    logic [1:0]   m_op;
    bit           mon_en;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active = 1'b0;
            m_e      = 0;
        end else begin
            m_idle = !m_active || (m_e >= m_len + 1);
            if (m_active && m_e < 1000) m_e++;
            if (m_idle && start === 1'b1) begin
                m_in     = in_s;
                m_op     = shift_s;
                m_len    = (amt_s == 0 || (shift_s == 2'b00 && !ROT)) ? 0 : int'(amt_s);
                m_e      = 0;
                m_active = 1'b1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [W:0] r;
            int         n;
            if (!m_active) begin
                check("mon_sout",  32'(sout),  32'h0);
                check("mon_carry", 32'(carry), 32'h0);
                check("mon_busy",  32'(busy),  32'h0);
                check("mon_done",  32'(done),  32'h0);
            end else begin
                n = (m_e < m_len) ? m_e : m_len;
                r = model_shift(m_in, m_op, n);
                check("mon_sout",  32'(sout),  32'(r[W-1:0]));
                check("mon_carry", 32'(carry), 32'(r[W]));
                check("mon_busy",  32'(busy),  32'(m_e < m_len));
                check("mon_done",  32'(done),  32'(m_e == m_len));
            end
        end
    end

    // Issue one operation and wait (bounded) for done; check literals.
    task automatic run_op(input string name, input logic [W-1:0] v, input logic [1:0] op,
                          input logic [AW-1:0] a, input logic [W-1:0] exp_sout,
                          input logic exp_carry, input int exp_edges);
        int edges;
        int nbusy;
        @(negedge clk);
        in_s = v; shift_s = op; amt_s = a; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 1;
        nbusy = int'(busy);
        while (done !== 1'b1 && edges < 40) begin
            @(negedge clk);
            edges++;
            nbusy += int'(busy);
        end
        check({name, "_latency"}, 32'(edges), 32'(exp_edges));
        check({name, "_busy_cycles"}, 32'(nbusy), 32'(exp_edges - 1));
        check({name, "_sout"}, 32'(sout), 32'(exp_sout));
        check({name, "_carry"}, 32'(carry), 32'(exp_carry));
    endtask

    initial begin
        bit saw_done;
        tests  = 0;
        fails  = 0;
        mon_en = 1'b0;
        start  = 1'b0;
        in_s   = '0;
        shift_s = 2'b00;
        amt_s  = '0;
        reset  = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_sout",  32'(sout),  32'h0);
        check("reset_carry", 32'(carry), 32'h0);
        check("reset_busy",  32'(busy),  32'h0);
        check("reset_done",  32'(done),  32'h0);
        #2 reset = 1'b0;
        mon_en = 1'b1;

        run_op("lsl1", 16'hF0CF, 2'b01, 4'd1, 16'hE19E, 1'b1, 2);
        run_op("lsr4", 16'hF0CF, 2'b10, 4'd4, 16'h0F0C, 1'b1, 5);
        run_op("asr4", 16'hF0CF, 2'b11, 4'd4, 16'hFF0C, 1'b1, 5);
        run_op("lsl4", 16'hF0CF, 2'b01, 4'd4, 16'h0CF0, 1'b1, 5);
        if (ROT) run_op("rot8", 16'hF0CF, 2'b00, 4'd8, 16'hCFF0, 1'b1, 9);
        else     run_op("pass8", 16'hF0CF, 2'b00, 4'd8, 16'hF0CF, 1'b0, 1);
        run_op("asr0", 16'hF0CF, 2'b11, 4'd0, 16'hF0CF, 1'b0, 1);
        run_op("asr15", 16'h8000, 2'b11, 4'd15, 16'hFFFF, 1'b0, 16);
        run_op("lsr15", 16'h8000, 2'b10, 4'd15, 16'h0001, 1'b0, 16);
        run_op("lsl15", 16'h0003, 2'b01, 4'd15, 16'h8000, 1'b1, 16);

        // Second start while busy must be ignored.
        @(negedge clk);
        in_s = 16'hF0CF; shift_s = 2'b10; amt_s = 4'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        in_s = 16'hAAAA; shift_s = 2'b01; amt_s = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("busy_ignore_sout",  32'(sout),  32'h0F0C);
        check("busy_ignore_carry", 32'(carry), 32'h1);
        check("hold_busy", 32'(busy), 32'h0);

        // Asynchronous reset in the middle of a long shift.
        @(negedge clk);
        in_s = 16'hF0CF; shift_s = 2'b10; amt_s = 4'd15; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_rst_sout", 32'(sout), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_done", 32'(done), 32'h0);
        @(negedge clk);
        #2 reset = 1'b0;
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("no_done_after_reset", 32'(saw_done), 32'h0);

        run_op("after_rst_asr4", 16'hF0CF, 2'b11, 4'd4, 16'hFF0C, 1'b1, 5);

        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit 200000 reached");
        $fatal(1);
    end

endmodule
